stage_4_mem: RTL and testbench
==============================

Name: stage_4_mem

Overview:
- Memory-access stage of the RV32I pipeline, directly downstream of the execute stage. It consumes the EX/MEM register contents: ALU result, forwarded store data, memory control and funct3.
- It runs the load/store handshake with the data cache and formats store data, byte enables and load data.
- It stalls the upstream pipeline while an access is outstanding.
- It produces the write-back value for the MEM/WB register and the mem_forward operand used by execute.

Parameters:
- XLEN, 32, datapath width (fixed at 32 for RV32I).
- TIMEOUT_CYCLES, 1024, number of BUSY cycles without dmem_resp before dmem_timeout is raised.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous, active-low reset. The module uses one clock, clk.
- mem_valid  input  1  EX/MEM holds a valid instruction.
- mem_read  input  1  instruction is a load.
- mem_write  input  1  instruction is a store.
- mem_funct3  input  3  load/store size and sign.
- mem_alu_out  input  32  effective address, or the ALU result for non-memory instructions.
- mem_rs2_out  input  32  store data, already forwarded.
- dmem_resp  input  1  data cache response.
- dmem_rdata  input  32  data cache read word.
- dmem_read  output  1  read request.
- dmem_write  output  1  write request.
- dmem_address  output  32  word-aligned address.
- dmem_wdata  output  32  store data, lane-aligned.
- dmem_byte_enable  output  4  byte write mask.
- mem_stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- wb_valid  output  1  MEM/WB may capture this cycle.
- wb_data  output  32  load result, or mem_alu_out passed through.
- mem_forward  output  32  value forwarded to execute (equal to wb_data).
- misalign  output  1  one-cycle flag: misaligned or illegal funct3 access, which was suppressed.
- dmem_timeout  output  1  sticky watchdog flag.

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset (rst=0, asynchronous) forces:
  - state IDLE;
  - dmem_read=0, dmem_write=0, dmem_address=0, dmem_wdata=0, dmem_byte_enable=0;
  - the wait counter, dmem_timeout and the captured load data to 0.
- Combinational outputs after reset follow the IDLE rules below. With mem_valid=0 that gives mem_stall=0, wb_valid=0, misalign=0.
- IDLE, non-memory instruction or mem_valid=0:
  - mem_stall=0, wb_valid=mem_valid, wb_data=mem_alu_out, zero added latency.
- IDLE, mem_valid and exactly one of read/write, aligned, legal funct3:
  - mem_stall=1 combinationally.
  - Registered request captured at the clock edge: dmem_address = {addr[31:2],2'b00}, dmem_wdata, dmem_byte_enable, dmem_read/dmem_write.
  - Next state BUSY.
- BUSY:
  - Requests held stable; mem_stall=1; the wait counter increments and saturates.
  - On dmem_resp: drop dmem_read/dmem_write at the edge, capture dmem_rdata, go to DONE.
  - When the counter reaches TIMEOUT_CYCLES: dmem_timeout=1 until reset. The FSM keeps waiting.
- DONE:
  - mem_stall=0, wb_valid=1.
  - wb_data = formatted captured load data for loads, or mem_alu_out for stores.
  - Next state IDLE. EX/MEM advances at this edge.
- Minimum load/store latency: 3 cycles (IDLE, BUSY with dmem_resp in its first cycle, DONE).
- Store formatting, with off = addr[1:0]:
  - SB (000): wdata = {4{rs2[7:0]}}, byte_enable = 4'b0001 << off.
  - SH (001): wdata = {2{rs2[15:0]}}, byte_enable = 4'b0011 << off.
  - SW (010): wdata = rs2, byte_enable = 4'b1111.
- Load formatting, selecting the lane by off:
  - LB (000) and LH (001) sign-extend.
  - LW (010) passes the word.
  - LBU (100) and LHU (101) zero-extend.
  - byte_enable is 4'b1111 for reads.
- Misaligned accesses are suppressed: halfword with addr[0]=1, or word with addr[1:0]!=0. Illegal funct3 is also suppressed: loads 011/110/111, stores other than 000/001/010. For a suppressed access in IDLE:
  - no request is issued;
  - misalign=1 and wb_valid=1 for that cycle;
  - wb_data=0 for a load, mem_alu_out for a store;
  - mem_stall=0.
- mem_read and mem_write both set: treated as illegal and suppressed as above.
- dmem_resp in IDLE or DONE: ignored.
- Inputs must be stable while mem_stall=1. Changes to the mem_* inputs during BUSY do not alter the held request.
- Reset asserted during BUSY: requests are dropped immediately and the FSM returns to IDLE. A later dmem_resp is ignored.

Test Plan:
- LW, addr 0x0000_1004, dmem_rdata 0xDEAD_BEEF, resp on the first BUSY cycle -> dmem_address 0x1004, byte_enable 4'b1111, mem_stall high for 2 cycles, DONE wb_data 0xDEAD_BEEF, wb_valid=1.
- LB at 0x1003, rdata 0x80AA_BBCC -> wb_data 0xFFFF_FF80. LBU at the same address -> 0x0000_0080. LHU at 0x1002 -> 0x0000_80AA.
- SB at 0x2001, rs2 0x1234_5678 -> dmem_write=1, dmem_address 0x2000, wdata 0x7878_7878, byte_enable 4'b0010. SH at 0x2002 -> wdata 0x5678_5678, byte_enable 4'b1100.
- dmem_resp delayed 5 cycles -> request signals and address constant, mem_stall=1 for 6 cycles, then one DONE cycle. With TIMEOUT_CYCLES=4: dmem_timeout rises and stays high.
- LW at 0x1002 -> no dmem_read, misalign=1 for one cycle, wb_data=0, mem_stall=0. An ADD passing mem_alu_out 0x55 -> wb_data 0x55 in the same cycle.
- Assert rst low during BUSY, then send dmem_resp -> dmem_read drops immediately, state IDLE, wb_valid=0, the response is ignored.

Source files
------------

// File: rtl/stage_4_mem.sv
// RV32I memory-access stage: data cache handshake, store/load lane formatting,
// pipeline stall generation and the write-back / forward value.
module stage_4_mem #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_alu_out,
  input  logic [XLEN-1:0] mem_rs2_out,
  input  logic            dmem_resp,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            dmem_read,
  output logic            dmem_write,
  output logic [XLEN-1:0] dmem_address,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_byte_enable,
  output logic            mem_stall,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] mem_forward,
  output logic            misalign,
  output logic            dmem_timeout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]      state;
  logic [CNT_W-1:0] wait_cnt;
  logic [XLEN-1:0] load_data_q;
  logic [2:0]      req_funct3;
  logic [1:0]      req_off;
  logic            req_is_load;

  logic [1:0]      off;
  logic            is_access;
  logic            load_legal;
  logic            store_legal;
  logic            misaligned;
  logic            suppress;
  logic            issue;
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_be;
  logic [XLEN-1:0] shifted;
  logic [15:0]     lane_half;
  logic [XLEN-1:0] load_fmt;

  assign off       = mem_alu_out[1:0];
  assign is_access = mem_valid & (mem_read | mem_write);

  always_comb begin
    load_legal  = 1'b0;
    store_legal = 1'b0;
    case (mem_funct3)
      3'b000, 3'b001, 3'b010: begin
        load_legal  = 1'b1;
        store_legal = 1'b1;
      end
      3'b100, 3'b101: load_legal = 1'b1;
      default: ;
    endcase
  end

  // Both read and write set is treated as an illegal encoding.
  assign misaligned = ((mem_funct3[1:0] == 2'b01) & off[0]) |
                      ((mem_funct3[1:0] == 2'b10) & (off != 2'b00));
  assign suppress   = is_access & ((mem_read & mem_write) |
                                   (mem_read ? ~load_legal : ~store_legal) |
                                   misaligned);
  assign issue      = (state == IDLE) & is_access & ~suppress;

  always_comb begin
    st_wdata = mem_rs2_out;
    st_be    = 4'b1111;
    case (mem_funct3[1:0])
      2'b00: begin
        st_wdata = {4{mem_rs2_out[7:0]}};
        st_be    = 4'b0001 << off;
      end
      2'b01: begin
        st_wdata = {2{mem_rs2_out[15:0]}};
        st_be    = 4'b0011 << off;
      end
      default: ;
    endcase
  end

  // Load formatting works from the request captured at issue, not the live inputs.
  assign shifted   = load_data_q >> {req_off, 3'b000};
  assign lane_half = req_off[1] ? load_data_q[31:16] : load_data_q[15:0];

  always_comb begin
    load_fmt = load_data_q;
    case (req_funct3)
      3'b000:  load_fmt = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_fmt = {{(XLEN-16){lane_half[15]}}, lane_half};
      3'b100:  load_fmt = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  load_fmt = {{(XLEN-16){1'b0}}, lane_half};
      default: ;
    endcase
  end

  always_comb begin
    mem_stall = 1'b0;
    wb_valid  = 1'b0;
    wb_data   = mem_alu_out;
    misalign  = 1'b0;
    case (state)
      IDLE: begin
        if (suppress) begin
          misalign = 1'b1;
          wb_valid = 1'b1;
          wb_data  = mem_read ? '0 : mem_alu_out;
        end else if (issue) begin
          mem_stall = 1'b1;
        end else begin
          wb_valid = mem_valid;
        end
      end
      BUSY: mem_stall = 1'b1;
      DONE: begin
        wb_valid = 1'b1;
        wb_data  = req_is_load ? load_fmt : mem_alu_out;
      end
      default: ;
    endcase
  end

  assign mem_forward = wb_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= '0;
      dmem_wdata       <= '0;
      dmem_byte_enable <= 4'b0000;
      wait_cnt         <= '0;
      dmem_timeout     <= 1'b0;
      load_data_q      <= '0;
      req_funct3       <= 3'b000;
      req_off          <= 2'b00;
      req_is_load      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            state            <= BUSY;
            dmem_read        <= mem_read;
            dmem_write       <= mem_write;
            dmem_address     <= {mem_alu_out[XLEN-1:2], 2'b00};
            dmem_wdata       <= mem_write ? st_wdata : '0;
            dmem_byte_enable <= mem_write ? st_be : 4'b1111;
            req_funct3       <= mem_funct3;
            req_off          <= off;
            req_is_load      <= mem_read;
            wait_cnt         <= '0;
          end
        end
        BUSY: begin
          if (dmem_resp) begin
            dmem_read   <= 1'b0;
            dmem_write  <= 1'b0;
            load_data_q <= dmem_rdata;
            state       <= DONE;
          end else begin
            // Watchdog only flags the stall; the access keeps waiting.
            if (wait_cnt != CNT_W'(TIMEOUT_CYCLES))
              wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1))
              dmem_timeout <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_4_mem.sv
// Directed testbench for stage_4_mem, built with a short watchdog (TIMEOUT_CYCLES=4).
module tb_stage_4_mem;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_out;
  logic [31:0] mem_rs2_out;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic        mem_stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [31:0] mem_forward;
  logic        misalign;
  logic        dmem_timeout;

  int vectors = 0;
  int miscompares = 0;

  int          sc;
  logic        rr, ww, st, dv, dq, hg;
  logic [31:0] ra, rwd, dd, df;
  logic [3:0]  rbe;

  stage_4_mem #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_funct3(mem_funct3), .mem_alu_out(mem_alu_out), .mem_rs2_out(mem_rs2_out),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
    .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_data(wb_data),
    .mem_forward(mem_forward), .misalign(misalign), .dmem_timeout(dmem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one access, answers after 'delay' BUSY cycles and records what the DUT did.
  task automatic run_access(input logic rd_i, input logic wr_i, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rs2,
                            input logic [31:0] rdata, input int delay, input logic perturb,
                            output int stall_cnt, output logic req_rd, output logic req_wr,
                            output logic [31:0] req_addr, output logic [31:0] req_wdata,
                            output logic [3:0] req_be, output logic stable,
                            output logic [31:0] done_data, output logic [31:0] done_fwd,
                            output logic done_valid, output logic done_req, output logic hung);
    int cycles;
    mem_valid = 1'b1; mem_read = rd_i; mem_write = wr_i; mem_funct3 = f3;
    mem_alu_out = addr; mem_rs2_out = rs2; dmem_rdata = rdata; dmem_resp = 1'b0;
    #1;
    stall_cnt = 0; cycles = 0; stable = 1'b1;
    req_rd = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    while (mem_stall === 1'b1 && cycles < 40) begin
      stall_cnt++;
      if (cycles == 1) begin
        req_rd = dmem_read; req_wr = dmem_write; req_addr = dmem_address;
        req_wdata = dmem_wdata; req_be = dmem_byte_enable;
      end else if (cycles > 1) begin
        if ({dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable} !==
            {req_rd, req_wr, req_addr, req_wdata, req_be})
          stable = 1'b0;
      end
      if (cycles >= 1) begin
        dmem_resp = (cycles == delay);
        if (perturb) begin
          mem_alu_out = (cycles == delay) ? addr : ~addr;
          mem_rs2_out = (cycles == delay) ? rs2 : ~rs2;
        end
      end
      step();
      cycles++;
    end
    hung = (cycles >= 40);
    dmem_resp = 1'b0;
    done_data = wb_data; done_fwd = mem_forward; done_valid = wb_valid;
    done_req = dmem_read | dmem_write;
    mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_funct3 = 3'b000;
    mem_alu_out = '0; mem_rs2_out = '0; dmem_resp = 1'b0; dmem_rdata = '0;
    #2 rst = 1'b0;
    #1;
    vectors++; if ({dmem_read, dmem_write} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_req: got %b required 00", {dmem_read, dmem_write}); end
    vectors++; if (dmem_address !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_addr: got %h required 0", dmem_address); end
    vectors++; if (dmem_wdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_wdata: got %h required 0", dmem_wdata); end
    vectors++; if (dmem_byte_enable !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_be: got %b required 0000", dmem_byte_enable); end
    vectors++; if ({mem_stall, wb_valid, misalign, dmem_timeout} !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_flags: got %b required 0000", {mem_stall, wb_valid, misalign, dmem_timeout}); end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_loads();
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 1, 1'b0,
               sc, rr, ww, ra, rwd, rbe, st, dd, df, dv, dq, hg);
    vectors++; if (sc !== 2) begin miscompares++; $display("[TB] FAIL lw_stall_cycles: got %0d required 2", sc); end
    vectors++; if ({rr, ww} !== 2'b10) begin miscompares++; $display("[TB] FAIL lw_req: got %b required 10", {rr, ww}); end
    vectors++; if (ra !== 32'h0000_1004) begin miscompares++; $display("[TB] FAIL lw_addr: got %h required 00001004", ra); end
    vectors++; if (rbe !== 4'b1111) begin miscompares++; $display("[TB] FAIL lw_be: got %b required 1111", rbe); end
    vectors++; if (dd !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL lw_wb_data: got %h required deadbeef", dd); end
    vectors++; if (df !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL lw_forward: got %h required deadbeef", df); end
    vectors++; if ({dv, dq, hg} !== 3'b100) begin miscompares++; $display("[TB] FAIL lw_done: got valid/req/hang %b required 100", {dv, dq, hg}); end

    run_access(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 1, 1'b0,
               sc, rr, ww, ra, rwd, rbe, st, dd, df, dv, dq, hg);
    vectors++; if (ra !== 32'h0000_1000) begin miscompares++; $display("[TB] FAIL lb_addr: got %h required 00001000", ra); end
    vectors++; if (dd !== 32'hFFFF_FF80) begin miscompares++; $display("[TB] FAIL lb_data: got %h required ffffff80", dd); end

    run_access(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 1, 1'b0,
               sc, rr, ww, ra, rwd, rbe, st, dd, df, dv, dq, hg);
    vectors++; if (dd !== 32'h0000_0080) begin miscompares++; $display("[TB] FAIL lbu_data: got %h required 00000080", dd); end

    run_access(1'b1, 1'b0, 3'b101, 32'h0000_1002, 32'h0, 32'h80AA_BBCC, 1, 1'b0,
               sc, rr, ww, ra, rwd, rbe, st, dd, df, dv, dq, hg);
    vectors++; if (dd !== 32'h0000_80AA) begin miscompares++; $display("[TB] FAIL lhu_data: got %h required 000080aa", dd); end

    run_access(1'b1, 1'b0, 3'b001, 32'h0000_1002, 32'h0, 32'h80AA_BBCC, 1, 1'b0,
               sc, rr, ww, ra, rwd, rbe, st, dd, df, dv, dq, hg);
    vectors++; if (dd !== 32'hFFFF_80AA) begin miscompares++; $display("[TB] FAIL lh_data: got %h required ffff80aa", dd); end

    run_access(1'b1, 1'b0, 3'b000, 32'h0000_1001, 32'h0, 32'h80AA_BBCC, 1, 1'b0,
               sc, rr, ww, ra, rwd, rbe, st, dd, df, dv, dq, hg);
    vectors++; if (dd !== 32'hFFFF_FFBB) begin miscompares++; $display("[TB] FAIL lb_lane1_data: got %h required ffffffbb", dd); end
  endtask

  task automatic test_stores();
    run_access(1'b0, 1'b1, 3'b000, 32'h0000_2001, 32'h1234_5678, 32'h0, 1, 1'b0,
               sc, rr, ww, ra, rwd, rbe, st, dd, df, dv, dq, hg);
    vectors++; if ({rr, ww} !== 2'b01) begin miscompares++; $display("[TB] FAIL sb_req: got %b required 01", {rr, ww}); end
    vectors++; if (ra !== 32'h0000_2000) begin miscompares++; $display("[TB] FAIL sb_addr: got %h required 00002000", ra); end
    vectors++; if (rwd !== 32'h7878_7878) begin miscompares++; $display("[TB] FAIL sb_wdata: got %h required 78787878", rwd); end
    vectors++; if (rbe !== 4'b0010) begin miscompares++; $display("[TB] FAIL sb_be: got %b required 0010", rbe); end
    vectors++; if ({dd, dv} !== {32'h0000_2001, 1'b1}) begin miscompares++; $display("[TB] FAIL sb_wb: got %h/%b required 00002001/1", dd, dv); end

    run_access(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_5678, 32'h0, 1, 1'b0,
               sc, rr, ww, ra, rwd, rbe, st, dd, df, dv, dq, hg);
    vectors++; if (rwd !== 32'h5678_5678) begin miscompares++; $display("[TB] FAIL sh_wdata: got %h required 56785678", rwd); end
    vectors++; if (rbe !== 4'b1100) begin miscompares++; $display("[TB] FAIL sh_be: got %b required 1100", rbe); end

    run_access(1'b0, 1'b1, 3'b010, 32'h0000_2004, 32'h1234_5678, 32'h0, 1, 1'b0,
               sc, rr, ww, ra, rwd, rbe, st, dd, df, dv, dq, hg);
    vectors++; if ({ra, rwd, rbe} !== {32'h0000_2004, 32'h1234_5678, 4'b1111}) begin miscompares++; $display("[TB] FAIL sw_req: got %h %h %b required 00002004 12345678 1111", ra, rwd, rbe); end
  endtask

  task automatic test_delayed_resp();
    vectors++; if (dmem_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_initial: got %b required 0", dmem_timeout); end
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'h0BAD_F00D, 4, 1'b0,
               sc, rr, ww, ra, rwd, rbe, st, dd, df, dv, dq, hg);
    vectors++; if (sc !== 5) begin miscompares++; $display("[TB] FAIL delay4_stall: got %0d required 5", sc); end
    vectors++; if (dmem_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL delay4_timeout: got %b required 0", dmem_timeout); end

    run_access(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'hAAAA_5555, 32'h0BAD_F00D, 5, 1'b1,
               sc, rr, ww, ra, rwd, rbe, st, dd, df, dv, dq, hg);
    vectors++; if (sc !== 6) begin miscompares++; $display("[TB] FAIL delay5_stall: got %0d required 6", sc); end
    vectors++; if (st !== 1'b1) begin miscompares++; $display("[TB] FAIL delay5_stable: got %b required 1", st); end
    vectors++; if ({rr, ra} !== {1'b1, 32'h0000_3000}) begin miscompares++; $display("[TB] FAIL delay5_req: got %b %h required 1 00003000", rr, ra); end
    vectors++; if ({dd, dv, hg} !== {32'h0BAD_F00D, 1'b1, 1'b0}) begin miscompares++; $display("[TB] FAIL delay5_done: got %h %b %b required 0badf00d 1 0", dd, dv, hg); end
    vectors++; if (dmem_timeout !== 1'b1) begin miscompares++; $display("[TB] FAIL delay5_timeout: got %b required 1", dmem_timeout); end
    step(); step(); step();
    vectors++; if (dmem_timeout !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_sticky: got %b required 1", dmem_timeout); end
  endtask

  task automatic test_misalign();
    mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_funct3 = 3'b010; mem_alu_out = 32'h0000_1002;
    #1;
    vectors++; if ({misalign, wb_valid, mem_stall} !== 3'b110) begin miscompares++; $display("[TB] FAIL lw_mis_flags: got %b required 110", {misalign, wb_valid, mem_stall}); end
    vectors++; if (wb_data !== 32'h0) begin miscompares++; $display("[TB] FAIL lw_mis_data: got %h required 0", wb_data); end
    step();
    vectors++; if (dmem_read !== 1'b0) begin miscompares++; $display("[TB] FAIL lw_mis_noreq: got %b required 0", dmem_read); end
    mem_read = 1'b0; mem_alu_out = 32'h0000_0055;
    #1;
    vectors++; if ({misalign, wb_valid, mem_stall} !== 3'b010) begin miscompares++; $display("[TB] FAIL add_flags: got %b required 010", {misalign, wb_valid, mem_stall}); end
    vectors++; if ({wb_data, mem_forward} !== {32'h55, 32'h55}) begin miscompares++; $display("[TB] FAIL add_data: got %h/%h required 55/55", wb_data, mem_forward); end

    mem_write = 1'b1; mem_funct3 = 3'b011; mem_alu_out = 32'h0000_2000;
    #1;
    vectors++; if ({misalign, wb_valid, mem_stall, wb_data} !== {3'b110, 32'h0000_2000}) begin miscompares++; $display("[TB] FAIL st_illegal: got %b %h required 110 00002000", {misalign, wb_valid, mem_stall}, wb_data); end
    mem_read = 1'b1; mem_funct3 = 3'b010;
    #1;
    vectors++; if ({misalign, mem_stall} !== 2'b10) begin miscompares++; $display("[TB] FAIL rd_and_wr: got %b required 10", {misalign, mem_stall}); end
    mem_write = 1'b0; mem_funct3 = 3'b001; mem_alu_out = 32'h0000_1001;
    #1;
    vectors++; if ({misalign, mem_stall} !== 2'b10) begin miscompares++; $display("[TB] FAIL lh_odd: got %b required 10", {misalign, mem_stall}); end
    mem_funct3 = 3'b110; mem_alu_out = 32'h0000_1000;
    #1;
    vectors++; if ({misalign, mem_stall} !== 2'b10) begin miscompares++; $display("[TB] FAIL ld_illegal: got %b required 10", {misalign, mem_stall}); end
    step();
    vectors++; if ({dmem_read, dmem_write} !== 2'b00) begin miscompares++; $display("[TB] FAIL mis_noreq: got %b required 00", {dmem_read, dmem_write}); end
    mem_valid = 1'b0; mem_read = 1'b0;
    #1;
    vectors++; if ({misalign, wb_valid, mem_stall} !== 3'b000) begin miscompares++; $display("[TB] FAIL idle_novalid: got %b required 000", {misalign, wb_valid, mem_stall}); end
    step();
  endtask

  task automatic test_reset_busy();
    mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_funct3 = 3'b010;
    mem_alu_out = 32'h0000_4000; dmem_resp = 1'b0; dmem_rdata = 32'hCAFE_F00D;
    step();
    vectors++; if (dmem_read !== 1'b1) begin miscompares++; $display("[TB] FAIL rb_busy_req: got %b required 1", dmem_read); end
    mem_valid = 1'b0; mem_read = 1'b0; mem_alu_out = 32'h0000_0077;
    rst = 1'b0;
    #1;
    vectors++; if ({dmem_read, dmem_timeout, mem_stall, wb_valid} !== 4'b0000) begin miscompares++; $display("[TB] FAIL rb_drop: got %b required 0000", {dmem_read, dmem_timeout, mem_stall, wb_valid}); end
    #1 rst = 1'b1;
    dmem_resp = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++; if ({dmem_read, wb_valid, mem_stall, wb_data} !== {3'b000, 32'h0000_0077}) begin miscompares++; $display("[TB] FAIL rb_ignore_resp: got %b %h required 000 00000077", {dmem_read, wb_valid, mem_stall}, wb_data); end
    end
    dmem_resp = 1'b0;
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_delayed_resp();
    test_misalign();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
